// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared types and constants for the FIFO burst reader
package fifo_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Output buffer depth: one slot for FIFO read latency, one for back-pressure.
  localparam int BUF_DEPTH = 2;
  localparam int CNT_W     = 2;

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

endpackage

// File: rtl/stream_skid_buf.sv
// rtl/stream_skid_buf.sv - 2-entry in-order buffer with simultaneous push/pop
import fifo_rd_pkg::*;

module stream_skid_buf #(
  parameter int WIDTH = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Push,
  input  logic [WIDTH-1:0] i_Push_Data,
  input  logic             i_Pop,
  output logic [CNT_W-1:0] o_Count,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Data
);

  logic [CNT_W-1:0] r_Count;
  logic [WIDTH-1:0] r_Mem0;  // head entry, drives o_Data directly
  logic [WIDTH-1:0] r_Mem1;
  logic             w_Pop;
  logic             w_Push;

  // A pop frees a slot in the same cycle, so a full buffer can still take a push.
  assign w_Pop  = i_Pop && (r_Count != '0);
  assign w_Push = i_Push && ((r_Count != CNT_FULL) || w_Pop);

  // Shift-register style storage: head is always r_Mem0.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_Count <= '0;
      r_Mem0  <= '0;
      r_Mem1  <= '0;
    end else begin
      case ({w_Push, w_Pop})
        2'b10: begin
          if (r_Count == '0) r_Mem0 <= i_Push_Data;
          else               r_Mem1 <= i_Push_Data;
          r_Count <= r_Count + CNT_ONE;
        end
        2'b01: begin
          r_Mem0  <= r_Mem1;
          r_Count <= r_Count - CNT_ONE;
        end
        2'b11: begin
          if (r_Count == CNT_ONE) begin
            r_Mem0 <= i_Push_Data;
          end else begin
            r_Mem0 <= r_Mem1;
            r_Mem1 <= i_Push_Data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign o_Count = r_Count;
  assign o_Valid = (r_Count != '0);
  assign o_Data  = r_Mem0;

endmodule

// File: rtl/fifo_burst_reader.sv
// rtl/fifo_burst_reader.sv - burst read master turning a non-FWFT FIFO into a valid/ready stream
import fifo_rd_pkg::*;

module fifo_burst_reader #(
  parameter int WIDTH = 8,
  parameter int LEN_W = 8
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Start,
  input  logic [LEN_W-1:0] i_Len,
  output logic             o_Busy,
  output logic             o_Done,
  output logic             o_Rd_En,
  input  logic             i_Rd_DV,
  input  logic [WIDTH-1:0] i_Rd_Data,
  input  logic             i_Empty,
  output logic             o_Valid,
  input  logic             i_Ready,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_Last
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           r_State;
  logic [LEN_W-1:0] r_Len;
  logic [LEN_W-1:0] r_Issued;
  logic [LEN_W-1:0] r_Sent;
  logic             r_Inflight;
  logic             r_Done;
  logic             r_Busy;

  logic [CNT_W-1:0] w_Count;
  logic             w_Valid;
  logic [WIDTH-1:0] w_Data;
  logic             w_Pop;
  logic             w_Push;
  logic             w_Credit_Ok;
  logic             w_Rd_En;
  logic [LEN_W-1:0] w_Len_M1;

  assign w_Len_M1 = r_Len - LEN_ONE;
  assign w_Pop    = w_Valid && i_Ready;
  // Data returning with no read outstanding (e.g. after a reset abort) is dropped.
  assign w_Push   = i_Rd_DV && r_Inflight;

  // Buffered + in-flight words, less this cycle's pop, must leave room for one more.
  assign w_Credit_Ok = ({1'b0, w_Count} + {2'b00, r_Inflight})
                       < (3'(BUF_DEPTH) + {2'b00, w_Pop});

  assign w_Rd_En = (r_State == ST_READ) && !i_Empty && (r_Issued < r_Len) && w_Credit_Ok;

  stream_skid_buf #(.WIDTH(WIDTH)) u_buf (
    .i_Clk       (i_Clk),
    .i_Rst       (i_Rst),
    .i_Push      (w_Push),
    .i_Push_Data (i_Rd_Data),
    .i_Pop       (w_Pop),
    .o_Count     (w_Count),
    .o_Valid     (w_Valid),
    .o_Data      (w_Data)
  );

  // Tracks the single cycle of FIFO read latency.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) r_Inflight <= 1'b0;
    else       r_Inflight <= w_Rd_En;
  end

  // Burst FSM with issue/send counters and registered busy/done.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      r_State  <= ST_IDLE;
      r_Len    <= '0;
      r_Issued <= '0;
      r_Sent   <= '0;
      r_Done   <= 1'b0;
      r_Busy   <= 1'b0;
    end else begin
      r_Done <= 1'b0;
      case (r_State)
        ST_IDLE: begin
          if (i_Start) begin
            if (i_Len != '0) begin
              r_Len    <= i_Len;
              r_Issued <= '0;
              r_Sent   <= '0;
              r_Busy   <= 1'b1;
              r_State  <= ST_READ;
            end else begin
              r_Done <= 1'b1;
            end
          end
        end
        ST_READ: begin
          if (w_Rd_En) begin
            r_Issued <= r_Issued + LEN_ONE;
            if (r_Issued == w_Len_M1) r_State <= ST_DRAIN;
          end
          // The final pop cannot happen here: the last read always moves us to DRAIN first.
          if (w_Pop) r_Sent <= r_Sent + LEN_ONE;
        end
        ST_DRAIN: begin
          if (w_Pop) begin
            r_Sent <= r_Sent + LEN_ONE;
            if (r_Sent == w_Len_M1) begin
              r_State <= ST_DONE;
              r_Done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_Busy  <= 1'b0;
          r_State <= ST_IDLE;
        end
        default: r_State <= ST_IDLE;
      endcase
    end
  end

  assign o_Busy  = r_Busy;
  assign o_Done  = r_Done;
  assign o_Rd_En = w_Rd_En;
  assign o_Valid = w_Valid;
  assign o_Data  = w_Data;
  assign o_Last  = w_Valid && (r_Sent == w_Len_M1);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// tb/tb_fifo_burst_reader.sv - self-checking bench for fifo_burst_reader
module tb_fifo_burst_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       i_Start;
  logic [7:0] i_Len;
  logic       o_Busy, o_Done, o_Rd_En;
  logic       i_Rd_DV;
  logic [7:0] i_Rd_Data;
  logic       i_Empty;
  logic       o_Valid;
  logic       i_Ready;
  logic [7:0] o_Data;
  logic       o_Last;

  always #5 clk = ~clk;

  fifo_burst_reader #(.WIDTH(8), .LEN_W(8)) dut (
    .i_Clk(clk), .i_Rst(rst), .i_Start(i_Start), .i_Len(i_Len),
    .o_Busy(o_Busy), .o_Done(o_Done), .o_Rd_En(o_Rd_En),
    .i_Rd_DV(i_Rd_DV), .i_Rd_Data(i_Rd_Data), .i_Empty(i_Empty),
    .o_Valid(o_Valid), .i_Ready(i_Ready), .o_Data(o_Data), .o_Last(o_Last)
  );

  // FIFO model and stimulus controls
  logic [7:0] fifo_q[$];
  bit         pend_dv;
  logic [7:0] pend_data;
  bit         start_req;
  logic [7:0] len_req;
  int         ready_mode;
  bit         rand_empty;
  bit         hold_empty;
  int         cyc, start_cyc;

  // Observations of the current burst
  logic [7:0] got_d[$];
  bit         got_l[$];
  int         rd_cnt, acc, viol, done_cnt, done_cyc, first_acc, last_acc;
  bit         busy_seen;

  int n_pass, n_total;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic tick();
    bit pop;
    @(negedge clk);
    i_Start = start_req;
    i_Len   = len_req;
    if (start_req) start_cyc = cyc;
    start_req = 1'b0;
    i_Rd_DV   = pend_dv;
    i_Rd_Data = pend_dv ? pend_data : 8'($urandom);
    case (ready_mode)
      0:       i_Ready = 1'b1;
      1:       i_Ready = cyc[0];
      default: i_Ready = 1'($urandom_range(0, 1));
    endcase
    i_Empty = (fifo_q.size() == 0) || hold_empty || (rand_empty && ($urandom_range(0, 3) == 0));
    #1;
    pop = o_Valid && i_Ready;
    if (o_Rd_En) begin
      if (i_Empty || ((rd_cnt - acc) >= 2 + int'(pop))) viol++;
      pend_dv   = 1'b1;
      pend_data = (fifo_q.size() != 0) ? fifo_q.pop_front() : 8'h00;
      rd_cnt++;
    end else begin
      pend_dv = 1'b0;
    end
    if (pop) begin
      got_d.push_back(o_Data);
      got_l.push_back(o_Last);
      if (first_acc < 0) first_acc = cyc;
      last_acc = cyc;
      acc++;
    end
    if (o_Done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (o_Busy) busy_seen = 1'b1;
    cyc++;
  endtask

  task automatic clear_obs();
    got_d.delete();
    got_l.delete();
    rd_cnt = 0; acc = 0; viol = 0; done_cnt = 0;
    done_cyc = -1; first_acc = -1; last_acc = -1;
    busy_seen = 1'b0;
  endtask

  task automatic start_burst(input logic [7:0] len);
    clear_obs();
    start_req = 1'b1;
    len_req   = len;
  endtask

  task automatic run_done(input int budget, output bit timed_out);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      tick();
      n++;
    end
    timed_out = (done_cnt == 0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_Start = 0; i_Len = 0; i_Rd_DV = 0; i_Rd_Data = 0; i_Empty = 1; i_Ready = 1;
    repeat (3) @(negedge clk);
    #1;
    n_total++;
    if ({o_Busy, o_Done, o_Rd_En, o_Valid, o_Last, o_Data} !== 13'h0)
      $display("FAIL reset_outputs got %b required 0", {o_Busy, o_Done, o_Rd_En, o_Valid, o_Last, o_Data});
    else n_pass++;
    rst = 1'b0;
    clear_obs();
    // Stray read data with nothing in flight must not enter the stream
    pend_dv = 1'b1; pend_data = 8'h5A;
    tick();
    tick();
    n_total++;
    if (o_Valid !== 1'b0 || acc != 0)
      $display("FAIL stray_rd_dv got valid=%b acc=%0d required valid=0 acc=0", o_Valid, acc);
    else n_pass++;
  endtask

  task automatic test_basic();
    bit to;
    logic [3:0] lastv;
    fifo_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    ready_mode = 0; rand_empty = 0; hold_empty = 0;
    start_burst(8'd4);
    run_done(50, to);
    n_total++;
    if (to || got_d.size() != 4) $display("FAIL basic_count got %0d words timeout=%0d required 4", got_d.size(), to);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (i >= got_d.size() || got_d[i] !== 8'(8'h10 + i))
        $display("FAIL basic_data[%0d] got %h required %h", i, (i < got_d.size()) ? got_d[i] : 8'hxx, 8'(8'h10 + i));
      else n_pass++;
    end
    lastv = '0;
    for (int i = 0; i < got_l.size() && i < 4; i++) lastv[i] = got_l[i];
    n_total++;
    if (lastv !== 4'b1000) $display("FAIL basic_last got %b required 1000", lastv);
    else n_pass++;
    n_total++;
    if (first_acc != start_cyc + 3) $display("FAIL basic_latency got %0d required %0d", first_acc - start_cyc, 3);
    else n_pass++;
    n_total++;
    if (last_acc != first_acc + 3) $display("FAIL basic_throughput got span %0d required 3", last_acc - first_acc);
    else n_pass++;
    n_total++;
    if (done_cyc != last_acc + 1) $display("FAIL basic_done_timing got %0d required %0d", done_cyc, last_acc + 1);
    else n_pass++;
    n_total++;
    if (rd_cnt != 4 || viol != 0) $display("FAIL basic_reads got rd=%0d viol=%0d required rd=4 viol=0", rd_cnt, viol);
    else n_pass++;
    tick();
    n_total++;
    if (o_Busy !== 1'b0 || done_cnt != 1) $display("FAIL basic_idle got busy=%b done_cnt=%0d required busy=0 done_cnt=1", o_Busy, done_cnt);
    else n_pass++;
  endtask

  task automatic test_toggle_ready();
    bit to;
    int errs = 0;
    fifo_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    ready_mode = 1;
    start_burst(8'd4);
    run_done(100, to);
    for (int i = 0; i < 4; i++)
      if (i >= got_d.size() || got_d[i] !== 8'(8'h10 + i) || got_l[i] != (i == 3)) errs++;
    n_total++;
    if (to || got_d.size() != 4 || errs != 0)
      $display("FAIL toggle_stream got %0d words %0d errors timeout=%0d required 4 words 0 errors", got_d.size(), errs, to);
    else n_pass++;
    n_total++;
    if (viol != 0 || rd_cnt != 4) $display("FAIL toggle_credit got viol=%0d rd=%0d required viol=0 rd=4", viol, rd_cnt);
    else n_pass++;
  endtask

  task automatic test_empty_stall();
    bit to;
    int errs = 0;
    fifo_q.delete();
    ready_mode = 0;
    start_burst(8'd3);
    repeat (6) tick();
    n_total++;
    if (rd_cnt != 0 || o_Busy !== 1'b1) $display("FAIL empty_stall got rd=%0d busy=%b required rd=0 busy=1", rd_cnt, o_Busy);
    else n_pass++;
    fifo_q = '{8'hA0, 8'hA1, 8'hA2};
    run_done(50, to);
    for (int i = 0; i < 3; i++)
      if (i >= got_d.size() || got_d[i] !== 8'(8'hA0 + i) || got_l[i] != (i == 2)) errs++;
    n_total++;
    if (to || got_d.size() != 3 || errs != 0 || viol != 0)
      $display("FAIL empty_resume got %0d words %0d errors viol=%0d timeout=%0d required 3 words 0 errors", got_d.size(), errs, viol, to);
    else n_pass++;
  endtask

  task automatic test_zero_len();
    fifo_q = '{8'h77};
    clear_obs();
    start_req = 1'b1; len_req = 8'd0;
    tick();
    tick();
    n_total++;
    if (done_cnt != 1 || done_cyc != start_cyc + 1)
      $display("FAIL zero_done got cnt=%0d at +%0d required cnt=1 at +1", done_cnt, done_cyc - start_cyc);
    else n_pass++;
    repeat (3) tick();
    n_total++;
    if (rd_cnt != 0 || busy_seen || done_cnt != 1)
      $display("FAIL zero_quiet got rd=%0d busy_seen=%0d done_cnt=%0d required 0 0 1", rd_cnt, busy_seen, done_cnt);
    else n_pass++;
    fifo_q.delete();
  endtask

  task automatic test_reset_mid_burst();
    bit to;
    int n = 0;
    int errs = 0;
    logic [7:0] exp[$];
    fifo_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hC0, 8'hC1, 8'hC2, 8'hC3};
    ready_mode = 0;
    start_burst(8'd5);
    while (acc < 2 && n < 50) begin
      tick();
      n++;
    end
    n_total++;
    if (acc != 2) $display("FAIL midrst_progress got acc=%0d required 2", acc);
    else n_pass++;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_total++;
    if ({o_Busy, o_Done, o_Rd_En, o_Valid, o_Last, o_Data} !== 13'h0)
      $display("FAIL midrst_outputs got %b required 0", {o_Busy, o_Done, o_Rd_En, o_Valid, o_Last, o_Data});
    else n_pass++;
    #1 rst = 1'b0;
    exp.delete();
    exp.push_back(fifo_q[0]);
    exp.push_back(fifo_q[1]);
    start_burst(8'd2);
    run_done(50, to);
    for (int i = 0; i < 2; i++)
      if (i >= got_d.size() || got_d[i] !== exp[i] || got_l[i] != (i == 1)) errs++;
    n_total++;
    if (to || got_d.size() != 2 || errs != 0 || rd_cnt != 2)
      $display("FAIL midrst_next got %0d words %0d errors rd=%0d timeout=%0d required 2 words 0 errors rd=2", got_d.size(), errs, rd_cnt, to);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    bit to;
    int errs = 0;
    logic [7:0] exp[$];
    fifo_q.delete();
    exp.delete();
    for (int i = 0; i < 8; i++) begin
      fifo_q.push_back(8'($urandom));
      if (i < 5) exp.push_back(fifo_q[i]);
    end
    ready_mode = 2;
    start_burst(8'd5);
    repeat (3) tick();
    start_req = 1'b1; len_req = 8'd7;
    run_done(200, to);
    repeat (4) tick();
    for (int i = 0; i < 5; i++)
      if (i >= got_d.size() || got_d[i] !== exp[i]) errs++;
    n_total++;
    if (to || rd_cnt != 5 || got_d.size() != 5 || errs != 0)
      $display("FAIL busy_start got rd=%0d words=%0d errors=%0d timeout=%0d required rd=5 words=5 errors=0", rd_cnt, got_d.size(), errs, to);
    else n_pass++;
    n_total++;
    if (done_cnt != 1 || o_Busy !== 1'b0)
      $display("FAIL busy_start_done got done_cnt=%0d busy=%b required 1 0", done_cnt, o_Busy);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit to;
    int len, derr, lerr;
    logic [7:0] exp[$];
    ready_mode = 2; rand_empty = 1;
    for (int b = 0; b < 6; b++) begin
      len = (b == 5) ? 255 : $urandom_range(1, 20);
      fifo_q.delete();
      exp.delete();
      for (int i = 0; i < len + $urandom_range(0, 4); i++) begin
        fifo_q.push_back(8'($urandom));
        if (i < len) exp.push_back(fifo_q[i]);
      end
      start_burst(8'(len));
      run_done(4000, to);
      derr = 0; lerr = 0;
      for (int i = 0; i < len; i++) begin
        if (i >= got_d.size() || got_d[i] !== exp[i]) derr++;
        if (i < got_l.size() && got_l[i] != (i == len - 1)) lerr++;
      end
      n_total++;
      if (to || got_d.size() != len || derr != 0)
        $display("FAIL b2b_data[%0d] got %0d words %0d errors timeout=%0d required %0d words 0 errors", b, got_d.size(), derr, to, len);
      else n_pass++;
      n_total++;
      if (lerr != 0) $display("FAIL b2b_last[%0d] got %0d misplaced required 0", b, lerr);
      else n_pass++;
      n_total++;
      if (viol != 0 || rd_cnt != len) $display("FAIL b2b_reads[%0d] got rd=%0d viol=%0d required rd=%0d viol=0", b, rd_cnt, viol, len);
      else n_pass++;
      n_total++;
      if (done_cyc != last_acc + 1 || done_cnt != 1)
        $display("FAIL b2b_done[%0d] got done at %0d cnt=%0d required at %0d cnt=1", b, done_cyc, done_cnt, last_acc + 1);
      else n_pass++;
    end
    rand_empty = 0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; cyc = 0; start_cyc = 0;
    pend_dv = 0; pend_data = 0; start_req = 0; len_req = 0;
    ready_mode = 0; rand_empty = 0; hold_empty = 0;
    clear_obs();
    test_reset();
    test_basic();
    test_toggle_ready();
    test_empty_stall();
    test_zero_len();
    test_reset_mid_burst();
    test_start_while_busy();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
# fifo_burst_reader

Read-side master for the team FIFO in standard (non-FWFT) mode. Given a start command and word count, it pulls exactly that many words out of the FIFO read port and presents them on a valid/ready output stream, with a last-word marker and a done pulse. A 2-entry output buffer absorbs the FIFO's one-cycle read latency and downstream back-pressure. It sits between a FIFO instance and any consumer that needs a handshaked stream.

## Interface
- WIDTH, 8: data width; must match the FIFO's WIDTH.
- LEN_W, 8: width of the burst length field; maximum burst is 2^LEN_W-1 words.

Ports:
- i_Clk  in  1  single clock for all logic.
- i_Rst  in  1  asynchronous, active-high reset.
- i_Start  in  1  one-cycle command pulse; sampled only in IDLE.
- i_Len  in  LEN_W  burst length in words; sampled with i_Start.
- o_Busy  out  1  high in every state except IDLE.
- o_Done  out  1  one-cycle pulse when the burst completes.
- o_Rd_En  out  1  FIFO read enable.
- i_Rd_DV  in  1  FIFO read data valid; asserted one cycle after o_Rd_En.
- i_Rd_Data  in  WIDTH  FIFO read data.
- i_Empty  in  1  FIFO empty flag.
- o_Valid  out  1  output word valid.
- i_Ready  in  1  consumer accepts the word when o_Valid && i_Ready.
- o_Data  out  WIDTH  output word.
- o_Last  out  1  high with the final word of the burst.

## Operation
States:
- **IDLE**
  - i_Start with i_Len != 0: latch i_Len into r_Len, clear r_Issued and r_Sent, and go to READ.
  - i_Start with i_Len == 0: pulse o_Done on the next cycle and stay in IDLE.
- **READ**
  - Assert o_Rd_En when all hold: !i_Empty, r_Issued < r_Len, and buf_count + inflight − pop < 2. Here pop = o_Valid && i_Ready.
  - Each read increments r_Issued. inflight is 1 in the cycle after o_Rd_En.
  - When r_Issued reaches r_Len, go to DRAIN.
- **DRAIN**
  - No reads are issued.
  - When the pop of word number r_Len occurs, go to DONE.
- **DONE**
  - Assert o_Done for one cycle, then return to IDLE.

Data path and counters:
- A word arriving with i_Rd_DV is pushed into the 2-entry buffer, in order. Output order matches FIFO order.
- r_Sent counts pops. o_Last = o_Valid && (r_Sent == r_Len−1).
- The credit rule guarantees the buffer never overflows. A push and a pop in the same cycle are both honoured.
- i_Rd_DV with no read in flight is ignored and the data is discarded.
- i_Start while o_Busy is high is ignored.
- Counters are LEN_W bits wide and never wrap, because r_Issued is capped at r_Len.

## Timing
- Reset:
  - State is IDLE; all counters and the buffer are cleared.
  - o_Busy, o_Done, o_Rd_En, o_Valid and o_Last are 0; o_Data is 0.
  - Reset mid-burst aborts immediately. In-flight FIFO data returning after reset is ignored.
- Latency with a non-empty FIFO and i_Ready high:
  - i_Start sampled at edge 0.
  - o_Rd_En high in cycle 1.
  - i_Rd_DV in cycle 2.
  - o_Valid in cycle 3.
- Sustained throughput is 1 word/clock when i_Ready and !i_Empty hold.
- o_Rd_En is combinational from registered state, i_Empty and i_Ready. All other outputs are registered.
- Back-pressure: with i_Ready low, at most 2 words are read ahead, then o_Rd_En stays low. o_Valid, o_Data and o_Last stay stable until accepted.
- An empty FIFO stalls reads without error. The burst resumes one cycle after i_Empty falls.
- o_Done fires the cycle after the last pop.
- A new i_Start is accepted the cycle after o_Done.

## Structure
- Package fifo_rd_pkg holds:
  - state encodings (IDLE, READ, DRAIN, DONE),
  - the buffer depth constant (2).
- Sub-module stream_skid_buf: 2-entry in-order buffer with a push/pop interface, count output, and simultaneous push/pop support.
- The top level holds the FSM, counters and credit logic.

## Test plan
- FIFO preloaded with 0x10–0x13, i_Len=4, i_Ready=1 -> o_Data 0x10, 0x11, 0x12, 0x13 on 4 consecutive cycles starting 3 cycles after i_Start. o_Last with 0x13; o_Done the following cycle.
- Same burst with i_Ready toggling 1/0 each cycle -> same order, no duplicates or drops. o_Rd_En never asserted while buf_count + inflight == 2 with no pop.
- i_Len=3 with the FIFO empty for 5 cycles after start, then 0xA0–0xA2 written -> o_Rd_En stays low while empty; stream 0xA0–0xA2 with o_Last on 0xA2.
- i_Len=0 -> o_Done pulses 1 cycle later, o_Rd_En never asserts, o_Busy stays low.
- i_Rst asserted mid-burst after 2 of 5 words -> all outputs 0 asynchronously, state IDLE. A new i_Len=2 burst then reads the next 2 FIFO words correctly.
- i_Start pulsed again during a busy burst -> ignored; exactly r_Len words are read.
